// File: rtl/booth_dot_accumulator.sv
// Dot-product accumulator fed by the 32x32 Booth multiplier.
// Sums len signed products into a wide register and hands the result out.
module booth_dot_accumulator #(
  parameter int PW    = 64,
  parameter int AW    = 72,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  input  logic [PW-1:0]    p_in,
  output logic             p_ready,
  output logic [AW-1:0]    acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    acc_out_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             ovf_q;

  logic [AW-1:0]    p_ext;
  logic [AW-1:0]    sum_d;
  logic             add_ovf;
  logic             accept;
  logic             last;

  // Sign-extend the product and form the wrapped sum with its overflow bit.
  always_comb begin
    p_ext   = AW'($signed(p_in));
    sum_d   = acc_q + p_ext;
    add_ovf = (acc_q[AW-1] == p_ext[AW-1]) &&
              (sum_d[AW-1] != acc_q[AW-1]);
    accept  = (state_q == S_ACCUM) && p_valid;
    last    = (cnt_q == len_q - LEN_W'(1));
  end

  // Job sequencer: idle -> accumulate -> hold result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      acc_out_q <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            if (len == '0) begin
              acc_out_q <= '0;
              state_q   <= S_DONE;
            end else begin
              len_q   <= len;
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_q <= sum_d;
            cnt_q <= cnt_q + LEN_W'(1);
            if (add_ovf) ovf_q <= 1'b1;
            if (last) begin
              acc_out_q <= sum_d;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign p_ready   = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign acc_out   = acc_out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Bench for booth_dot_accumulator: queue-based reference model,
// per-cycle compare, directed jobs plus randomized jobs.
module tb_booth_dot_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  len;
  logic        p_valid;
  logic [63:0] p_in;
  logic        p_ready;
  logic [71:0] acc_out;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  booth_dot_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .p_valid(p_valid), .p_in(p_in), .p_ready(p_ready),
    .acc_out(acc_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 waiting for a job, 1 collecting products, 2 result offered
  int          m_mode = 0;
  int          m_len  = 0;
  logic [63:0] m_q[$];
  logic [71:0] m_acc  = '0;
  bit          m_ovf  = 1'b0;

  // Wrapped sum of all products so far; overflow when any exact
  // partial sum leaves the 72-bit signed range.
  task automatic fold(output logic [71:0] s, output bit o);
    logic signed [79:0] w;
    s = '0;
    o = 1'b0;
    foreach (m_q[i]) begin
      w = 80'($signed(s)) + 80'($signed(m_q[i]));
      if (w > 80'sh7F_FFFF_FFFF_FFFF_FFFF ||
          w < -80'sh80_0000_0000_0000_0000) o = 1'b1;
      s = w[71:0];
    end
  endtask

  always @(posedge clk) begin
    logic [71:0] s;
    bit          o;
    if (rst) begin
      m_mode = 0;
      m_q.delete();
      m_acc = '0;
      m_ovf = 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_ovf = 1'b0;
          m_q.delete();
          if (len == 0) begin
            m_acc  = '0;
            m_mode = 2;
          end else begin
            m_len  = int'(len);
            m_mode = 1;
          end
        end
        1: if (p_valid) begin
          m_q.push_back(p_in);
          fold(s, o);
          m_ovf = o;
          if (m_q.size() == m_len) begin
            m_acc  = s;
            m_mode = 2;
          end
        end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  task automatic check(string nm, logic [71:0] got, logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      72'(busy),      72'(m_mode != 0));
      check("p_ready",   72'(p_ready),   72'(m_mode == 1));
      check("out_valid", 72'(out_valid), 72'(m_mode == 2));
      check("acc_out",   acc_out,        m_acc);
      check("overflow",  72'(overflow),  72'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int n);
    start = 1'b1;
    len   = 10'(n);
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [63:0] p, input int gap);
    int t = 0;
    repeat (gap) step();
    p_valid = 1'b1;
    p_in    = p;
    while (!p_ready && t < 100) begin
      step();
      t++;
    end
    if (!p_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout got 0 exp 1 at %0t", $time);
    end
    step();
    p_valid = 1'b0;
    p_in    = $urandom;
  endtask

  task automatic finish_job(input int hold, input logic [71:0] exp,
                            input bit exp_o, input bit spulse,
                            input bit lit);
    int t = 0;
    while (!out_valid && t < 50) begin
      step();
      t++;
    end
    n_chk++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL done_timeout got 0 exp 1 at %0t", $time);
    end
    if (lit) begin
      check("lit_acc_dut",   acc_out,          exp);
      check("lit_acc_model", m_acc,            exp);
      check("lit_ovf_dut",   72'(overflow),    72'(exp_o));
      check("lit_ovf_model", 72'(m_ovf),       72'(exp_o));
    end
    repeat (hold) step();
    out_ready = 1'b1;
    start     = spulse;
    len       = 10'd3;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    p_valid   = 1'b0;
    p_in      = '0;
    out_ready = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    check("rst_acc",   acc_out,          72'd0);
    check("rst_valid", 72'(out_valid),   72'd0);
    check("rst_busy",  72'(busy),        72'd0);

    // cancelling products back-to-back
    go(4);
    send(-64'sd25, 0);
    send(64'sd25, 0);
    send(64'sd25, 0);
    send(-64'sd25, 0);
    finish_job(0, 72'd0, 1'b0, 1'b0, 1'b1);
    check("idle_busy", 72'(busy), 72'd0);

    // gaps between terms, negative result
    go(3);
    send(64'sd48, 2);
    send(-64'sd72, 2);
    send(-64'sd5, 2);
    finish_job(0, -72'sd29, 1'b0, 1'b0, 1'b1);

    // empty job, held result
    go(0);
    finish_job(5, 72'd0, 1'b0, 1'b0, 1'b1);

    // 512 x 2^62 wraps to -2^71
    go(512);
    for (int i = 0; i < 512; i++) send(64'h4000_0000_0000_0000, 0);
    finish_job(0, 72'h80_0000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
    go(1);
    send(64'd1, 0);
    finish_job(0, 72'd1, 1'b0, 1'b0, 1'b1);

    // reset mid-job
    go(4);
    send(64'sd5, 0);
    send(64'sd5, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_acc",  acc_out,        72'd0);
    check("mrst_busy", 72'(busy),      72'd0);
    check("mrst_ovf",  72'(overflow),  72'd0);
    go(1);
    send(-64'sd5, 0);
    finish_job(0, -72'sd5, 1'b0, 1'b0, 1'b1);

    // start noise during ACCUM and during the DONE handshake
    go(3);
    start = 1'b1;
    send(64'sd10, 0);
    send(64'sd20, 1);
    start = 1'b0;
    send(64'sd30, 0);
    finish_job(1, 72'd60, 1'b0, 1'b1, 1'b1);
    go(2);
    send(64'sd1, 0);
    send(64'sd2, 0);
    finish_job(0, 72'd3, 1'b0, 1'b0, 1'b1);

    // randomized jobs
    for (int j = 0; j < 30; j++) begin
      int n;
      n = $urandom_range(0, 8);
      go(n);
      for (int i = 0; i < n; i++) begin
        start = 1'($urandom_range(0, 1));
        send({$urandom, $urandom}, $urandom_range(0, 2));
      end
      start = 1'b0;
      finish_job($urandom_range(0, 3), '0, 1'b0,
                 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
